// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 raster timing, derived sync windows and shared types.
package vga_pkg;
    localparam int CLK_DIV   = 4;
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam logic SYNC_POL = 1'b0;
    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;
    localparam int COLOR_W  = 12;
    typedef logic [9:0] cnt_t;
    typedef logic [COLOR_W-1:0] color_t;
    function automatic logic in_span(cnt_t x, int lo, int hi);
        return x >= cnt_t'(lo) && x <= cnt_t'(hi);
    endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing outputs plus the processor register feeding the re-timer.
interface vga_timing_gen_if;
    import vga_pkg::*;
    logic   pix_tick;
    cnt_t   h_count;
    cnt_t   v_count;
    logic   video_on;
    logic   HS;
    logic   VS;
    logic   frame_start;
    color_t regout_in;
    color_t regout_frame;
    modport master (
        input  regout_in,
        output pix_tick, h_count, v_count, video_on, HS, VS, frame_start, regout_frame
    );
    modport slave (
        output regout_in,
        input  pix_tick, h_count, v_count, video_on, HS, VS, frame_start, regout_frame
    );
endinterface

// File: rtl/vga_timing_gen_pix_clk_en.sv
// pix_clk_en: divides clk by CLK_DIV into a registered one-clk pixel enable.
module pix_clk_en #(
    parameter int CLK_DIV = vga_pkg::CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic pix_tick
);
    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [W-1:0] div_q, div_d;
    logic         tick_q, tick_d;
    always_comb begin
        tick_d = div_q == W'(CLK_DIV - 1);
        div_d  = tick_d ? '0 : div_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end
    assign pix_tick = tick_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: H/V raster counters, sync/visible decode and a frame-stable copy of regout_in.
module vga_timing_gen #(
    parameter int   CLK_DIV   = vga_pkg::CLK_DIV,
    parameter int   H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int   H_FP      = vga_pkg::H_FP,
    parameter int   H_SYNC    = vga_pkg::H_SYNC,
    parameter int   H_BP      = vga_pkg::H_BP,
    parameter int   V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int   V_FP      = vga_pkg::V_FP,
    parameter int   V_SYNC    = vga_pkg::V_SYNC,
    parameter int   V_BP      = vga_pkg::V_BP,
    parameter logic SYNC_POL  = vga_pkg::SYNC_POL
) (
    input logic               clk,
    input logic               reset,
    vga_timing_gen_if.master  bus
);
    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int VS_START = V_VISIBLE + V_FP;
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_width_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit 10-bit counters");
    end
    logic            pix_tick;
    vga_pkg::cnt_t   h_q, h_d, v_q, v_d;
    logic            video_on_q, video_on_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic            h_wrap, v_wrap;
    vga_pkg::color_t rf_q, rf_d;
    pix_clk_en #(.CLK_DIV(CLK_DIV)) u_pix_clk_en (
        .clk     (clk),
        .reset   (reset),
        .pix_tick(pix_tick)
    );
    // Sync/visible flags are decoded from the next counter values so they line up with the counters.
    always_comb begin
        h_wrap     = h_q == vga_pkg::cnt_t'(H_TOTAL - 1);
        v_wrap     = v_q == vga_pkg::cnt_t'(V_TOTAL - 1);
        h_d        = !pix_tick ? h_q : h_wrap ? '0 : h_q + 1'b1;
        v_d        = !(pix_tick && h_wrap) ? v_q : v_wrap ? '0 : v_q + 1'b1;
        video_on_d = pix_tick ? vga_pkg::in_span(h_d, 0, H_VISIBLE - 1) &&
                                vga_pkg::in_span(v_d, 0, V_VISIBLE - 1) : video_on_q;
        hs_d       = pix_tick ? (vga_pkg::in_span(h_d, HS_START, HS_START + H_SYNC - 1) ?
                                 SYNC_POL : ~SYNC_POL) : hs_q;
        vs_d       = pix_tick ? (vga_pkg::in_span(v_d, VS_START, VS_START + V_SYNC - 1) ?
                                 SYNC_POL : ~SYNC_POL) : vs_q;
        fs_d       = pix_tick && h_wrap && v_wrap;
        rf_d       = (pix_tick && h_wrap && v_q == vga_pkg::cnt_t'(V_VISIBLE - 1)) ?
                     bus.regout_in : rf_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q        <= '0;
            v_q        <= '0;
            video_on_q <= 1'b0;
            hs_q       <= ~SYNC_POL;
            vs_q       <= ~SYNC_POL;
            fs_q       <= 1'b0;
            rf_q       <= '0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            video_on_q <= video_on_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            fs_q       <= fs_d;
            rf_q       <= rf_d;
        end
    end
    assign bus.pix_tick     = pix_tick;
    assign bus.h_count      = h_q;
    assign bus.v_count      = v_q;
    assign bus.video_on     = video_on_q;
    assign bus.HS           = hs_q;
    assign bus.VS           = vs_q;
    assign bus.frame_start  = fs_q;
    assign bus.regout_frame = rf_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for a default-timing and a shrunken-timing instance.
module tb_vga_timing_gen;
    localparam int SD = 4, SHV = 16, SHF = 2, SHS = 4, SHB = 3, SVV = 12, SVF = 2, SVS = 2, SVB = 3;
    localparam int SHT = SHV + SHF + SHS + SHB, SVT = SVV + SVF + SVS + SVB;
    typedef struct packed {
        logic       tick;
        logic [9:0] h;
        logic [9:0] v;
        logic       von;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [11:0] rf;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [11:0] regout = 12'h000;
    int compared = 0, mismatched = 0, n = 0;
    logic [11:0] rf_d = 12'h000, rf_s = 12'h000;
    exp_t q_d[$], q_s[$];
    exp_t act_d, act_s;
    always #5 clk = ~clk;
    vga_timing_gen_if bus_d();
    vga_timing_gen_if bus_s();
    assign bus_d.regout_in = regout;
    assign bus_s.regout_in = regout;
    vga_timing_gen dut_d (.clk(clk), .reset(reset), .bus(bus_d.master));
    vga_timing_gen #(
        .CLK_DIV(SD), .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .SYNC_POL(1'b0)
    ) dut_s (.clk(clk), .reset(reset), .bus(bus_s.master));
    assign act_d = {bus_d.pix_tick, bus_d.h_count, bus_d.v_count, bus_d.video_on,
                    bus_d.HS, bus_d.VS, bus_d.frame_start, bus_d.regout_frame};
    assign act_s = {bus_s.pix_tick, bus_s.h_count, bus_s.v_count, bus_s.video_on,
                    bus_s.HS, bus_s.VS, bus_s.frame_start, bus_s.regout_frame};
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp_v, $time);
        end
    endtask
    // Expected outputs as a closed-form function of clocks since reset release.
    function automatic exp_t model(int k, int d, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb, logic [11:0] rf);
        int ht = hv + hf + hsw + hb;
        int vt = vv + vf + vsw + vb;
        int adv = (k < 1) ? 0 : (k - 1) / d;
        int pos = adv % (ht * vt);
        int h = pos % ht;
        int v = pos / ht;
        exp_t e;
        e.tick = k >= d && k % d == 0;
        e.h    = 10'(h);
        e.v    = 10'(v);
        e.von  = adv > 0 && h < hv && v < vv;
        e.hs   = !(h >= hv + hf && h < hv + hf + hsw);
        e.vs   = !(v >= vv + vf && v < vv + vf + vsw);
        e.fs   = k > 1 && (k - 1) % d == 0 && pos == 0;
        e.rf   = rf;
        return e;
    endfunction
    function automatic bit captures(int k, int d, int ht, int vt, int vv);
        return k > 1 && (k - 1) % d == 0 && ((k - 1) / d) % (ht * vt) == vv * ht;
    endfunction
    task automatic step();
        @(posedge clk);
        if (reset) begin
            n = 0;
            rf_d = 12'h000;
            rf_s = 12'h000;
        end else begin
            n++;
            if (captures(n, 4, 800, 525, 480)) rf_d = regout;
            if (captures(n, SD, SHT, SVT, SVV)) rf_s = regout;
        end
        q_d.push_back(model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33, rf_d));
        q_s.push_back(model(n, SD, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, rf_s));
        @(negedge clk);
        check("dflt_state", act_d, q_d.pop_front());
        check("small_state", act_s, q_s.pop_front());
    endtask
    initial begin
        int first_tick = 0, fs_cnt = 0, last_fs = 0, period = 0;
        int hs_clk = 0, von_clk = 0, vs_ticks = 0;
        reset = 1'b1;
        repeat (5) step();
        check("rst_hs", bus_d.HS, 1'b1);
        check("rst_vs", bus_d.VS, 1'b1);
        check("rst_von", bus_d.video_on, 1'b0);
        check("rst_rf", bus_s.regout_frame, 12'h000);
        reset = 1'b0;
        for (int i = 1; i <= 4200; i++) begin
            step();
            if (bus_s.pix_tick && first_tick == 0) first_tick = i;
            if (bus_s.frame_start) begin
                fs_cnt++;
                if (last_fs != 0) period = i - last_fs;
                last_fs = i;
            end
            if (!bus_d.HS && bus_d.v_count == 10'd0) hs_clk++;
            if (bus_d.video_on && bus_d.v_count == 10'd0) von_clk++;
            if (fs_cnt == 1 && bus_s.pix_tick && !bus_s.VS) vs_ticks++;
            if (i == 1800) check("rf_held_blank", bus_s.regout_frame, 12'h123);
            regout = (i == 300) ? 12'hABC : (i == 800) ? 12'h123 : (i == 1300) ? 12'h5A5 :
                     (i == 2500) ? 12'h777 : regout;
        end
        check("first_tick", first_tick, 4);
        check("frame_pulses", fs_cnt, 2);
        check("frame_period", period, SHT * SVT * SD);
        check("hs_line0_clk", hs_clk, 384);
        check("von_line0_clk", von_clk, 639 * 4);
        check("vs_ticks", vs_ticks, SVS * SHT);
        check("rf_cap2", bus_s.regout_frame, 12'h777);
        reset = 1'b1;
        step();
        check("mid_rst_h", bus_s.h_count, 10'd0);
        check("mid_rst_v", bus_s.v_count, 10'd0);
        check("mid_rst_hs", bus_s.HS, 1'b1);
        check("mid_rst_rf", bus_s.regout_frame, 12'h000);
        reset = 1'b0;
        for (int i = 1; i <= 600; i++) begin
            step();
            if (i == 4) check("rerun_tick", bus_s.pix_tick, 1'b1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
